// File: rtl/udma_cfg_apb_initiator_if.sv
// APB target side and cfg-bus initiator side of the
// uDMA configuration bridge, bundled for one port.
interface udma_cfg_apb_initiator_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 4
);
  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i;
  logic [31:0]               apb_pwdata_i;
  logic                      apb_pwrite_i;
  logic                      apb_psel_i;
  logic                      apb_penable_i;
  logic [31:0]               apb_prdata_o;
  logic                      apb_pready_o;
  logic                      apb_pslverr_o;
  logic [31:0]               cfg_data_o;
  logic [4:0]                cfg_addr_o;
  logic                      cfg_rwn_o;
  logic [N_PERIPHS-1:0]      cfg_valid_o;
  logic [32*N_PERIPHS-1:0]   cfg_data_i;
  logic [N_PERIPHS-1:0]      cfg_ready_i;

  modport slave (
    input  apb_paddr_i, apb_pwdata_i, apb_pwrite_i,
    input  apb_psel_i, apb_penable_i,
    output apb_prdata_o, apb_pready_o, apb_pslverr_o,
    output cfg_data_o, cfg_addr_o, cfg_rwn_o, cfg_valid_o,
    input  cfg_data_i, cfg_ready_i
  );

  modport master (
    output apb_paddr_i, apb_pwdata_i, apb_pwrite_i,
    output apb_psel_i, apb_penable_i,
    input  apb_prdata_o, apb_pready_o, apb_pslverr_o,
    input  cfg_data_o, cfg_addr_o, cfg_rwn_o, cfg_valid_o,
    output cfg_data_i, cfg_ready_i
  );
endinterface

// File: rtl/udma_cfg_apb_initiator.sv
// APB target that forwards each access as one cfg-bus
// request to a one-hot selected uDMA peripheral.
module udma_cfg_apb_initiator #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk_i,
  input logic rst_i,
  udma_cfg_apb_initiator_if.slave bus
);
  localparam int IDX_W = APB_ADDR_WIDTH - 7;
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W:0] NP = (IDX_W+1)'(N_PERIPHS);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, ACCESS, ERROR, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       addr_q, addr_d;
  logic             rwn_q, rwn_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        setup;
  logic        sel_ready;
  logic [31:0] sel_data;
  logic        to_hit;
  logic        unused_ok;

  assign setup = bus.apb_psel_i & ~bus.apb_penable_i;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  assign unused_ok = ^bus.apb_paddr_i[1:0];

  // pick the addressed responder's ready and read data
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = bus.cfg_ready_i[k];
        sel_data  = bus.cfg_data_i[32*k +: 32];
      end
    end
  end

  // state and captured request/response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      rwn_q    <= 1'b0;
      data_q   <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      rwn_q    <= rwn_d;
      data_q   <= data_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // next state: decode, wait for ready or time out, respond
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    rwn_d    = rwn_q;
    data_d   = data_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    cnt_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d  = bus.apb_paddr_i[APB_ADDR_WIDTH-1:7];
          addr_d = bus.apb_paddr_i[6:2];
          rwn_d  = ~bus.apb_pwrite_i;
          data_d = bus.apb_pwrite_i ? bus.apb_pwdata_i : '0;
          if ({1'b0, bus.apb_paddr_i[APB_ADDR_WIDTH-1:7]} < NP)
            state_d = ACCESS;
          else
            state_d = ERROR;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          prdata_d = rwn_q ? sel_data : '0;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (to_hit) begin
          prdata_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        prdata_d = '0;
        err_d    = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // one-hot valid only while the request is outstanding
  always_comb begin
    bus.cfg_valid_o = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      bus.cfg_valid_o[k] =
        (state_q == ACCESS) && (idx_q == IDX_W'(k));
    end
  end

  assign bus.apb_pready_o  = (state_q == RESP);
  assign bus.apb_prdata_o  = bus.apb_pready_o ? prdata_q : '0;
  assign bus.apb_pslverr_o = bus.apb_pready_o & err_q;
  assign bus.cfg_addr_o    = addr_q;
  assign bus.cfg_rwn_o     = rwn_q;
  assign bus.cfg_data_o    = data_q;
endmodule

// File: tb/tb_udma_cfg_apb_initiator.sv
// Directed vector bench for the uDMA cfg APB initiator.
// Bench acts as APB master and as all cfg responders.
module tb_udma_cfg_apb_initiator;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  udma_cfg_apb_initiator_if #(
    .APB_ADDR_WIDTH(12),
    .N_PERIPHS(4)
  ) bif ();

  udma_cfg_apb_initiator #(
    .APB_ADDR_WIDTH(12),
    .N_PERIPHS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;
    bit          drop_sel;
    logic [3:0]  exp_mask;
    int          exp_vc;
    logic [4:0]  exp_addr;
    bit          exp_rwn;
    logic [31:0] exp_data;
    logic [31:0] exp_prdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];
  vec_t post;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bif.apb_psel_i    = 1'b0;
    bif.apb_penable_i = 1'b0;
    bif.cfg_ready_i   = '0;
  endtask

  task automatic run(input vec_t v, input string nm);
    int   t;
    int   vc;
    int   lat;
    int   idx;
    bit   done;
    bit   quiet;
    bit   mask_ok;
    logic [4:0]  f_addr;
    logic        f_rwn;
    logic [31:0] f_data;
    logic [31:0] g_prdata;
    logic        g_err;
    t = 0; vc = 0; lat = 0; done = 0;
    quiet = 1; mask_ok = 1;
    f_addr = 'x; f_rwn = 'x; f_data = 'x;
    g_prdata = 'x; g_err = 'x;
    @(negedge clk);
    bif.apb_psel_i    = 1'b1;
    bif.apb_penable_i = 1'b0;
    bif.apb_paddr_i   = v.addr;
    bif.apb_pwdata_i  = v.wdata;
    bif.apb_pwrite_i  = v.write;
    bif.cfg_ready_i   = '0;
    for (int k = 0; k < 4; k++)
      bif.cfg_data_i[32*k +: 32] = 32'hDEAD_0000 | k;
    idx = int'(v.addr[11:7]);
    if (idx < 4) bif.cfg_data_i[32*idx +: 32] = v.rdata;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
      if (v.drop_sel) begin
        bif.apb_psel_i    = 1'b0;
        bif.apb_penable_i = 1'b0;
      end else begin
        bif.apb_penable_i = 1'b1;
      end
      if (bif.cfg_valid_o != '0) begin
        vc++;
        if (bif.cfg_valid_o !== v.exp_mask) mask_ok = 0;
        if (vc == 1) begin
          f_addr = bif.cfg_addr_o;
          f_rwn  = bif.cfg_rwn_o;
          f_data = bif.cfg_data_o;
        end
        bif.cfg_ready_i =
          (vc == v.ready_at) ? bif.cfg_valid_o : '0;
      end else begin
        bif.cfg_ready_i = '0;
      end
      if (bif.apb_pready_o) begin
        done     = 1;
        lat      = t;
        g_prdata = bif.apb_prdata_o;
        g_err    = bif.apb_pslverr_o;
      end else if (bif.apb_prdata_o != 0 ||
                   bif.apb_pslverr_o != 0) begin
        quiet = 0;
      end
    end
    idle_bus();
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_valid_cycles"}, vc, v.exp_vc);
    chk({nm, "_valid_mask"}, mask_ok, 1);
    chk({nm, "_prdata"}, g_prdata, v.exp_prdata);
    chk({nm, "_pslverr"}, g_err, v.exp_err);
    chk({nm, "_quiet_before_ready"}, quiet, 1);
    if (v.exp_vc > 0) begin
      chk({nm, "_cfg_addr"}, f_addr, v.exp_addr);
      chk({nm, "_cfg_rwn"}, f_rwn, v.exp_rwn);
      chk({nm, "_cfg_data"}, f_data, v.exp_data);
    end
  endtask

  initial begin
    bit no_resp;
    vecs[0] = '{1, 12'h18C, 32'hA5A5_0011, 32'h0, 1, 0,
                4'b1000, 1, 5'd3, 0, 32'hA5A5_0011, 32'h0, 0, 2};
    vecs[1] = '{0, 12'h088, 32'hFFFF_FFFF, 32'h31, 4, 0,
                4'b0010, 4, 5'd2, 1, 32'h0, 32'h31, 0, 5};
    vecs[2] = '{1, 12'h280, 32'h1111_2222, 32'h0, 1, 0,
                4'b0000, 0, 5'd0, 0, 32'h0, 32'h0, 1, 2};
    vecs[3] = '{0, 12'h100, 32'h0, 32'h7777_7777, 0, 0,
                4'b0100, 16, 5'd0, 1, 32'h0, 32'h0, 1, 17};
    vecs[4] = '{0, 12'h10C, 32'h0, 32'hCAFE_F00D, 16, 0,
                4'b0100, 16, 5'd3, 1, 32'h0, 32'hCAFE_F00D, 0, 17};
    vecs[5] = '{1, 12'h004, 32'h1234_5678, 32'h0, 1, 0,
                4'b0001, 1, 5'd1, 0, 32'h1234_5678, 32'h0, 0, 2};
    vecs[6] = '{0, 12'h07C, 32'h0, 32'h0BAD_BEEF, 1, 0,
                4'b0001, 1, 5'd31, 1, 32'h0, 32'h0BAD_BEEF, 0, 2};
    vecs[7] = '{0, 12'h200, 32'h0, 32'h0, 1, 0,
                4'b0000, 0, 5'd0, 0, 32'h0, 32'h0, 1, 2};
    vecs[8] = '{0, 12'h1FC, 32'h0, 32'h8000_0001, 2, 0,
                4'b1000, 2, 5'd31, 1, 32'h0, 32'h8000_0001, 0, 3};
    vecs[9] = '{0, 12'h094, 32'h0, 32'h5555_AAAA, 2, 1,
                4'b0010, 2, 5'd5, 1, 32'h0, 32'h5555_AAAA, 0, 3};
    post    = '{1, 12'h0A0, 32'h0F0F_1234, 32'h0, 1, 0,
                4'b0010, 1, 5'd8, 0, 32'h0F0F_1234, 32'h0, 0, 2};

    rst = 1'b1;
    bif.apb_paddr_i  = '0;
    bif.apb_pwdata_i = '0;
    bif.apb_pwrite_i = 1'b0;
    bif.cfg_data_i   = '0;
    idle_bus();
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(bif.cfg_valid_o), 0);
    chk("reset_apb", {bif.apb_pready_o, bif.apb_pslverr_o},
        0);
    chk("reset_prdata", bif.apb_prdata_o, 0);
    chk("reset_cfg",
        {bif.cfg_addr_o, bif.cfg_rwn_o}, 0);
    chk("reset_cfg_data", bif.cfg_data_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run(vecs[i], $sformatf("v%0d", i));

    repeat (2) @(negedge clk);
    chk("hold_cfg_addr", bif.cfg_addr_o, 5'd5);
    chk("hold_cfg_rwn", bif.cfg_rwn_o, 1);
    chk("idle_valid", 32'(bif.cfg_valid_o), 0);

    @(negedge clk);
    bif.apb_psel_i    = 1'b1;
    bif.apb_penable_i = 1'b0;
    bif.apb_paddr_i   = 12'h088;
    bif.apb_pwrite_i  = 1'b0;
    @(negedge clk);
    bif.apb_penable_i = 1'b1;
    chk("mid_valid_c1", 32'(bif.cfg_valid_o), 32'h2);
    @(negedge clk);
    chk("mid_valid_c2", 32'(bif.cfg_valid_o), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bif.cfg_valid_o), 0);
    chk("mid_rst_outs",
        {bif.apb_pready_o, bif.apb_pslverr_o,
         bif.cfg_rwn_o, bif.cfg_addr_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    no_resp = 1;
    repeat (3) begin
      @(negedge clk);
      if (bif.apb_pready_o || bif.cfg_valid_o != 0)
        no_resp = 0;
    end
    chk("mid_rst_no_resp", no_resp, 1);
    run(post, "post_rst");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/udma_cfg_apb_initiator.md
Name: udma_cfg_apb_initiator

Overview:
- APB slave that acts as the initiator of the uDMA peripheral configuration bus. It drives cfg_valid/cfg_rwn/cfg_addr/cfg_data toward N_PERIPHS register-interface responders and collects cfg_data/cfg_ready from them.
- Sits between the SoC APB interconnect and the per-peripheral register interfaces (I2C, SPI, UART, ...).
- Handles one-hot peripheral select, responder wait states, out-of-range decode errors and a responder timeout.

Parameters:
- APB_ADDR_WIDTH, 12: APB address width. Peripheral index = paddr[APB_ADDR_WIDTH-1:7]; register address = paddr[6:2].
- N_PERIPHS, 4: number of cfg responders, 1..(2^(APB_ADDR_WIDTH-7)).
- TIMEOUT_CYCLES, 16: maximum cycles cfg_valid is held without cfg_ready before an error response; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- apb_paddr_i  in  APB_ADDR_WIDTH  APB address
- apb_pwdata_i  in  32  APB write data
- apb_pwrite_i  in  1  APB write (1) / read (0)
- apb_psel_i  in  1  APB select
- apb_penable_i  in  1  APB enable
- apb_prdata_o  out  32  APB read data
- apb_pready_o  out  1  APB ready
- apb_pslverr_o  out  1  APB error
- cfg_data_o  out  32  write data, shared by all responders
- cfg_addr_o  out  5  register address, shared
- cfg_rwn_o  out  1  1 = read, 0 = write, shared
- cfg_valid_o  out  N_PERIPHS  one-hot request valid
- cfg_data_i  in  32*N_PERIPHS  responder read data; slice k = bits [32k+31:32k]
- cfg_ready_i  in  N_PERIPHS  responder ready

Behaviour:
- Reset (rst_i high, async): FSM=IDLE; all outputs 0; timeout counter 0; captured index/addr/data/rwn 0.
- FSM states: IDLE, ACCESS, ERROR, RESP.
- IDLE:
  - On an APB setup cycle (psel=1, penable=0), register the following: idx = paddr[APB_ADDR_WIDTH-1:7]; cfg_addr_o = paddr[6:2]; cfg_rwn_o = ~pwrite; cfg_data_o = pwrite ? pwdata : 0.
  - If idx < N_PERIPHS, go to ACCESS; otherwise go to ERROR.
  - psel=1 together with penable=1 in IDLE is ignored (no setup seen).
- ACCESS:
  - cfg_valid_o[idx]=1; all other bits 0.
  - Held each cycle until cfg_ready_i[idx]=1. The transfer completes in the cycle where valid and ready are both 1.
  - On completion: prdata_r = cfg_rwn_o ? cfg_data_i slice idx : 0; pslverr_r = 0; cfg_valid_o drops next cycle; go to RESP.
  - A responder that is always ready therefore sees exactly one valid cycle. This is mandatory, because responders apply write side effects and read-clear side effects on every valid cycle.
  - Timeout counter increments each ACCESS cycle without ready. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, deassert valid, set prdata_r=0 and pslverr_r=1, and go to RESP. Ready arriving in the same cycle as the terminal count wins: this is a normal completion.
  - The counter clears on leaving ACCESS.
- ERROR: no cfg_valid_o bit asserted; prdata_r=0, pslverr_r=1; go to RESP next cycle.
- RESP:
  - apb_pready_o=1, apb_prdata_o=prdata_r, apb_pslverr_o=pslverr_r, for exactly one cycle; go to IDLE.
  - apb_prdata_o and apb_pslverr_o are 0 whenever pready=0.
- Latency:
  - Setup cycle T0.
  - Valid at T1.
  - With ready at T1: pready at T2, i.e. 2 access-phase cycles.
  - Each wait cycle adds 1.
  - Decode error: pready at T2.
- APB protocol violation: if psel drops while in ACCESS, the cfg transfer still completes or times out normally. RESP is still entered for one cycle, then IDLE.
- Back-to-back: a new setup cycle is accepted in IDLE the cycle after RESP. No pipelining of outstanding requests.
- Reset mid-ACCESS: valid drops asynchronously; no response is issued.
- cfg_addr_o, cfg_rwn_o and cfg_data_o hold their values after the transfer until the next setup.

Test Plan:
- Write, ready tied 1: APB write paddr=0x18C (idx 3, reg 3), pwdata=0xA5A5_0011. Required: cfg_valid_o=4'b1000 for exactly 1 cycle, cfg_addr_o=3, cfg_rwn_o=0, cfg_data_o=0xA5A5_0011; pready next cycle; pslverr=0.
- Read, ready delayed: read paddr=0x088 (idx 1, reg 2); cfg_ready_i[1] asserted after 3 cycles with slice 1 = 0x0000_0031. Required: valid held 4 cycles; prdata=0x31 in the single pready cycle; pslverr=0.
- Decode error: N_PERIPHS=4, paddr=0x280 (idx 5). Required: cfg_valid_o stays 0; pready with pslverr=1 and prdata=0 at T2.
- Timeout: TIMEOUT_CYCLES=16, cfg_ready_i=0. Required: valid held 16 cycles then dropped; pready with pslverr=1, prdata=0. Repeat with ready arriving on cycle 16: normal completion, pslverr=0.
- Reset mid-access: assert rst_i during ACCESS cycle 2 of a read. Required: all outputs 0 immediately; after release a new write completes normally.
- Back-to-back: write then read to idx 0, ready=1. Required: two single-cycle valid pulses; the second setup is accepted the cycle after the first pready; rwn=0 then rwn=1.
